argmax_stream: RTL and testbench

// - Streaming, parametrised argmax for the classifier output stage.
// - Accepts NUM_CLASSES signed scores as LANES scores per beat and reduces each beat with a comparator tree.
// - Keeps a running (max value, max index) across beats and returns the winner with a valid/ready handshake.
// - Generalises the fixed 10-input combinational argmax; adds back-pressure, multi-beat frames and frame checking.

---
 rtl/argmax_stream_pkg.sv | 28 ++
 rtl/argmax_tree_comb.sv | 51 +++++
 rtl/argmax_stream.sv | 122 ++++++++++++
 tb/tb_argmax_stream.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/argmax_stream_pkg.sv
// Shared definitions for the streaming argmax: state encoding, frame sizing helpers
// and the two-input compare cell used by both the lane tree and the accumulator.
package argmax_stream_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int unsigned calc_beats(input int unsigned num_classes,
                                             input int unsigned lanes);
    return (num_classes + lanes - 1) / lanes;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned beats);
    return (beats < 1) ? 1 : $clog2(beats + 1);
  endfunction

  // Frame sizing for the default configuration (10 classes, 2 lanes).
  localparam int unsigned BEATS = calc_beats(10, 2);
  localparam int unsigned CNT_W = calc_cnt_w(BEATS);

endpackage

// Compare cell: the higher-index candidate b replaces a only when strictly larger,
// so a tie always keeps the lower class index.
`ifndef ARGMAX_B_WINS
`define ARGMAX_B_WINS(a_val, b_val) ($signed(b_val) > $signed(a_val))
`endif

// File: rtl/argmax_tree_comb.sv
// Combinational LANES-input argmax: pairwise tree over a power-of-two heap,
// masked lanes never win and ties keep the lower lane.
module argmax_tree_comb
  import argmax_stream_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned LANES       = 2
) (
  input  logic [BIT_WIDTH*LANES-1:0]   i_val,
  input  logic [INDEX_WIDTH*LANES-1:0] i_idx,
  input  logic [LANES-1:0]             i_mask,
  output logic [BIT_WIDTH-1:0]         o_val,
  output logic [INDEX_WIDTH-1:0]       o_idx
);

  localparam int unsigned LEAVES = 1 << $clog2(LANES);
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic [BIT_WIDTH-1:0]   w_val [NODES];
  logic [INDEX_WIDTH-1:0] w_idx [NODES];
  logic                   w_vld [NODES];

  // Node n has children 2n+1 (lower lanes) and 2n+2 (higher lanes); leaves start at LEAVES-1.
  always_comb begin
    for (int n = 0; n < int'(NODES); n++) begin
      w_val[n] = '0;
      w_idx[n] = '0;
      w_vld[n] = 1'b0;
    end
    for (int k = 0; k < int'(LANES); k++) begin
      w_val[int'(LEAVES) - 1 + k] = i_val[BIT_WIDTH*k +: BIT_WIDTH];
      w_idx[int'(LEAVES) - 1 + k] = i_idx[INDEX_WIDTH*k +: INDEX_WIDTH];
      w_vld[int'(LEAVES) - 1 + k] = i_mask[k];
    end
    for (int n = int'(LEAVES) - 2; n >= 0; n--) begin
      if (w_vld[2*n+2] && (!w_vld[2*n+1] || `ARGMAX_B_WINS(w_val[2*n+1], w_val[2*n+2]))) begin
        w_val[n] = w_val[2*n+2];
        w_idx[n] = w_idx[2*n+2];
      end else begin
        w_val[n] = w_val[2*n+1];
        w_idx[n] = w_idx[2*n+1];
      end
      w_vld[n] = w_vld[2*n+1] | w_vld[2*n+2];
    end
  end

  assign o_val = w_val[0];
  assign o_idx = w_idx[0];

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: reduces LANES scores per beat, keeps a running winner across
// the frame and holds the result under a valid/ready handshake.
module argmax_stream
  import argmax_stream_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LANES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH*LANES-1:0]   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [INDEX_WIDTH-1:0]       out_idx,
  output logic [BIT_WIDTH-1:0]         out_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_err
);

  localparam int unsigned FRAME_BEATS = calc_beats(NUM_CLASSES, LANES);
  localparam int unsigned BCNT_W      = calc_cnt_w(FRAME_BEATS);

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_nxt;
  logic [BCNT_W-1:0]            r_beat_cnt;
  logic [BIT_WIDTH-1:0]         r_acc_val;
  logic [INDEX_WIDTH-1:0]       r_acc_idx;
  logic                         r_out_valid;
  logic                         r_in_ready;
  logic                         r_frame_err;
  logic                         w_accept;
  logic                         w_is_last;
  logic [INDEX_WIDTH*LANES-1:0] w_lane_idx;
  logic [LANES-1:0]             w_lane_mask;
  logic [BIT_WIDTH-1:0]         w_beat_val;
  logic [INDEX_WIDTH-1:0]       w_beat_idx;

  assign w_accept  = in_valid && r_in_ready;
  assign w_is_last = (r_beat_cnt == BCNT_W'(FRAME_BEATS - 1));

  // Class number per lane; lanes past NUM_CLASSES on a ragged last beat are masked.
  always_comb begin
    int cls;
    cls         = 0;
    w_lane_idx  = '0;
    w_lane_mask = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      cls = int'(r_beat_cnt) * int'(LANES) + k;
      w_lane_idx[INDEX_WIDTH*k +: INDEX_WIDTH] = INDEX_WIDTH'(cls);
      w_lane_mask[k] = (cls < int'(NUM_CLASSES));
    end
  end

  argmax_tree_comb #(
    .BIT_WIDTH  (BIT_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH),
    .LANES      (LANES)
  ) u_tree (
    .i_val (in_data),
    .i_idx (w_lane_idx),
    .i_mask(w_lane_mask),
    .o_val (w_beat_val),
    .o_idx (w_beat_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_is_last ? DONE : ACCUM;
      ACCUM:   if (w_accept && w_is_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == DONE);
      r_in_ready  <= (w_state_nxt != DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_acc_val   <= '0;
      r_acc_idx   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_state == DONE && w_state_nxt == IDLE) begin
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
      end
      // First beat loads directly; later beats replace only on a strictly larger score.
      if (w_accept && (r_state == IDLE || `ARGMAX_B_WINS(r_acc_val, w_beat_val))) begin
        r_acc_val <= w_beat_val;
        r_acc_idx <= w_beat_idx;
      end
      if (w_accept && (in_last != w_is_last)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_idx   = r_acc_idx;
  assign out_val   = r_acc_val;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default 2-lane instance plus a ragged 4-lane instance.
module tb_argmax_stream;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [3:0]  out_idx;
  logic [7:0]  out_val;
  logic        out_valid, out_ready, frame_err;

  logic [31:0] g_data;
  logic        g_valid, g_last, g_ready;
  logic [3:0]  g_idx;
  logic [7:0]  g_val;
  logic        g_out_valid, g_out_ready, g_frame_err;

  int n_cmp = 0;
  int n_err = 0;

  argmax_stream dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_idx(out_idx), .out_val(out_val), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err)
  );

  argmax_stream #(.BIT_WIDTH(8), .INDEX_WIDTH(4), .NUM_CLASSES(10), .LANES(4)) u_rag (
    .clk(clk), .rst(rst), .in_data(g_data), .in_valid(g_valid), .in_last(g_last),
    .in_ready(g_ready), .out_idx(g_idx), .out_val(g_val), .out_valid(g_out_valid),
    .out_ready(g_out_ready), .frame_err(g_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] sc;
    int          eidx;
    int          eval;
  } vec_t;

  vec_t vecs[8];
  vec_t rags[3];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [79:0] mk(input int s0, input int s1, input int s2, input int s3,
                                     input int s4, input int s5, input int s6, input int s7,
                                     input int s8, input int s9);
    return {8'(s9), 8'(s8), 8'(s7), 8'(s6), 8'(s5), 8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  function automatic int sval(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Five beats back to back; err_beat forces in_last high on that beat as well.
  task automatic run_frame(input string nm, input logic [79:0] sc, input int err_beat,
                           input int eidx, input int eval);
    for (int b = 0; b < 5; b++) begin
      chk({nm, "_in_ready"}, int'(in_ready), 1);
      in_data  = sc[16*b +: 16];
      in_last  = (b == 4) || (b == err_beat);
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (b < 4) chk({nm, "_early_valid"}, int'(out_valid), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_idx"}, int'(out_idx), eidx);
    chk({nm, "_val"}, sval(out_val), eval);
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_released"}, int'(out_valid), 0);
    chk({nm, "_ready_again"}, int'(in_ready), 1);
  endtask

  // Three beats on the 4-lane instance; the two padding lanes of the last beat carry 127.
  task automatic run_rag(input string nm, input logic [79:0] sc, input int eidx, input int eval);
    for (int b = 0; b < 3; b++) begin
      chk({nm, "_in_ready"}, int'(g_ready), 1);
      g_data  = (b < 2) ? sc[32*b +: 32] : {16'h7f7f, sc[64 +: 16]};
      g_last  = (b == 2);
      g_valid = 1'b1;
      @(posedge clk); #1;
    end
    g_valid = 1'b0;
    g_last  = 1'b0;
    chk({nm, "_valid"}, int'(g_out_valid), 1);
    chk({nm, "_idx"}, int'(g_idx), eidx);
    chk({nm, "_val"}, sval(g_val), eval);
    chk({nm, "_ferr"}, int'(g_frame_err), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{mk(3, -5, 7, 7, 0, 1, -128, 2, 6, 127), 9, 127};
    vecs[1] = '{mk(-4, -4, -4, -4, -4, -4, -4, -4, -4, -4), 0, -4};
    vecs[2] = '{mk(0, 0, 0, 7, 0, 0, 0, 0, 7, 0), 3, 7};
    vecs[3] = '{mk(-128, -128, -128, -128, -127, -128, -128, -128, -128, -128), 4, -127};
    vecs[4] = '{mk(5, 5, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5};
    vecs[5] = '{mk(9, 10, 10, 9, 9, 9, 9, 9, 9, 9), 1, 10};
    vecs[6] = '{mk(100, 99, -1, 50, 0, 0, 0, 0, 0, 99), 0, 100};
    vecs[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, -1, 1), 9, 1};
    rags[0] = '{mk(1, 2, 3, 4, 5, 50, 6, 7, 8, 49), 5, 50};
    rags[1] = '{mk(-100, -100, -100, -100, -100, -100, -100, -100, -1, -100), 8, -1};
    rags[2] = '{mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128), 0, -128};

    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    g_data = '0;  g_valid = 1'b0;  g_last = 1'b0;  g_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    chk("reset_out_val", sval(out_val), 0);
    chk("reset_frame_err", int'(frame_err), 0);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sc, -1, vecs[i].eidx, vecs[i].eval);
      release_result($sformatf("vec%0d", i));
    end
    chk("vec_frame_err", int'(frame_err), 0);

    for (int i = 0; i < 3; i++) run_rag($sformatf("rag%0d", i), rags[i].sc, rags[i].eidx, rags[i].eval);

    // Back-pressure: result held for six cycles while a pending beat is offered and refused.
    out_ready = 1'b0;
    run_frame("bp1", vecs[0].sc, -1, 9, 127);
    in_data  = 16'h7f7f;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_in_ready", c), int'(in_ready), 0);
      chk($sformatf("bp_hold%0d_valid", c), int'(out_valid), 1);
      chk($sformatf("bp_hold%0d_idx", c), int'(out_idx), 9);
      chk($sformatf("bp_hold%0d_val", c), sval(out_val), 127);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result("bp1");
    chk("bp_frame_err", int'(frame_err), 0);
    run_frame("bp2", mk(1, 1, 1, 1, 1, 1, 1, 11, 1, 1), -1, 7, 11);
    release_result("bp2");

    // Early in_last on beat 2: flagged, frame still closes on the count, flag is sticky.
    run_frame("ferr", mk(0, 0, 33, 0, 0, 0, 0, 0, 0, 0), 1, 2, 33);
    chk("ferr_set", int'(frame_err), 1);
    release_result("ferr");
    run_frame("ferr_next", vecs[2].sc, -1, 3, 7);
    chk("ferr_sticky", int'(frame_err), 1);
    release_result("ferr_next");

    // Asynchronous reset after three beats of a frame.
    for (int b = 0; b < 3; b++) begin
      in_data  = mk(50, 1, 2, 3, 4, 5, 6, 7, 8, 9) >> (16 * b);
      in_last  = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_val", sval(out_val), 50);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_idx", int'(out_idx), 0);
    chk("async_rst_val", sval(out_val), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ferr", int'(frame_err), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    run_frame("fresh", mk(1, 2, 3, 4, 5, 6, 20, 7, 8, 9), -1, 6, 20);
    chk("fresh_frame_err", int'(frame_err), 0);
    release_result("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
